// File: rtl/cmd_proc_pkg.sv
// Shared definitions for the command processor: opcodes, response codes,
// FSM state encoding and command-decode helpers.
package cmd_proc_pkg;

  typedef enum logic [3:0] {
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2
  } opcode_e;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NACK = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SEND_HI,
    WAIT_HI,
    SEND_LAST,
    WAIT_LAST
  } state_e;

  // A command byte is [7:4] opcode, [3] range bit, [2:0] address.
  // The range bit set makes an otherwise valid WRITE/READ invalid.
  function automatic logic is_write_cmd(input logic [7:0] c);
    return (c[7:4] == OP_WRITE) && !c[3];
  endfunction

  function automatic logic is_read_cmd(input logic [7:0] c);
    return (c[7:4] == OP_READ) && !c[3];
  endfunction

endpackage

// File: rtl/cmd_regfile.sv
// 8 x 16-bit configuration register file.
//   clk, rst : clock, synchronous active-high reset (all registers to 0)
//   we       : write enable, one write per cycle
//   waddr    : write address
//   wdata    : write data
//   regs     : flat read image, register n at bits [16n+15:16n]
module cmd_regfile (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [15:0]  wdata,
  output logic [127:0] regs
);

  logic [7:0][15:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign regs = mem_q;

endmodule

// File: rtl/cmd_proc.sv
// Command processor behind the UART command wrapper. Accepts a 24-bit
// command, executes WRITE/READ against the register file and returns one
// or two response bytes via the snd_resp/resp/resp_sent handshake. A
// per-byte watchdog aborts a response that is never confirmed.
//   clk, rst     : clock, synchronous active-high reset
//   cmd_rdy      : full command available (level)
//   cmd, data    : command byte and 16-bit payload
//   clr_cmd_rdy  : acknowledge consumption of cmd/data (combinational in IDLE)
//   snd_resp     : one-cycle pulse launching transmission of resp
//   resp         : response byte, held until resp_sent
//   resp_sent    : transmitter done (level)
//   regs         : flat register-file image
//   wr_strobe    : one-cycle register write pulse, wr_addr valid with it
//   busy         : high whenever not IDLE
//   tx_err       : sticky watchdog flag, cleared by the next accepted command
module cmd_proc
  import cmd_proc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_rdy,
  input  logic [7:0]   cmd,
  input  logic [15:0]  data,
  output logic         clr_cmd_rdy,
  output logic         snd_resp,
  output logic [7:0]   resp,
  input  logic         resp_sent,
  output logic [127:0] regs,
  output logic         wr_strobe,
  output logic [2:0]   wr_addr,
  output logic         busy,
  output logic         tx_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  state_e          state_q;
  logic [7:0]      cmd_q;
  logic [15:0]     data_q;
  logic [7:0]      lo_q;
  logic [CntW-1:0] wd_cnt_q;

  logic [7:0][15:0] regs_arr;
  logic [15:0]      rd_word;
  logic             wd_expired;

  assign regs_arr   = regs;
  assign rd_word    = regs_arr[cmd_q[2:0]];
  assign wd_expired = (wd_cnt_q == CntLast);

  // Acceptance must be visible in the same cycle the command is latched.
  assign clr_cmd_rdy = !rst && (state_q == IDLE) && cmd_rdy;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      data_q    <= '0;
      lo_q      <= '0;
      wd_cnt_q  <= '0;
      resp      <= '0;
      snd_resp  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      tx_err    <= 1'b0;
    end else begin
      snd_resp  <= 1'b0;
      wr_strobe <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_rdy) begin
            cmd_q   <= cmd;
            data_q  <= data;
            tx_err  <= 1'b0;
            // Strobe is decoded here so it is high during EXEC itself.
            wr_strobe <= is_write_cmd(cmd);
            wr_addr   <= cmd[2:0];
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          snd_resp <= 1'b1;
          if (is_write_cmd(cmd_q)) begin
            resp    <= RESP_ACK;
            state_q <= SEND_LAST;
          end else if (is_read_cmd(cmd_q)) begin
            // Snapshot both bytes now; the low byte is not re-read later.
            resp    <= rd_word[15:8];
            lo_q    <= rd_word[7:0];
            state_q <= SEND_HI;
          end else begin
            resp    <= RESP_NACK;
            state_q <= SEND_LAST;
          end
        end
        SEND_HI: begin
          wd_cnt_q <= '0;
          state_q  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (resp_sent) begin
            resp     <= lo_q;
            snd_resp <= 1'b1;
            state_q  <= SEND_LAST;
          end else if (wd_expired) begin
            tx_err  <= 1'b1;
            state_q <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        SEND_LAST: begin
          wd_cnt_q <= '0;
          state_q  <= WAIT_LAST;
        end
        WAIT_LAST: begin
          if (resp_sent) begin
            state_q <= IDLE;
          end else if (wd_expired) begin
            tx_err  <= 1'b1;
            state_q <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cmd_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_strobe),
    .waddr (wr_addr),
    .wdata (data_q),
    .regs  (regs)
  );

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc: a vector table of commands with expected
// responses, plus hand-written timeout, back-to-back and reset sequences.
module tb_cmd_proc;

  localparam int unsigned TO = 16;
  localparam int NV = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_rdy;
  logic [7:0]   cmd;
  logic [15:0]  data;
  logic         clr_cmd_rdy;
  logic         snd_resp;
  logic [7:0]   resp;
  logic         resp_sent;
  logic [127:0] regs;
  logic         wr_strobe;
  logic [2:0]   wr_addr;
  logic         busy;
  logic         tx_err;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    int          nresp;
    logic [7:0]  r0;
    logic [7:0]  r1;
    bit          wr;
  } vec_t;

  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit snd_seen = 1'b0;
  bit tx_en = 1'b1;
  int tx_delay = 2;
  int tx_cnt = 0;
  int rise_cyc = -1;
  logic [15:0] shadow[8];

  cmd_proc #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .snd_resp    (snd_resp),
    .resp        (resp),
    .resp_sent   (resp_sent),
    .regs        (regs),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one clock; also models the transmitter, which drops resp_sent
  // on the edge where it samples snd_resp and raises it tx_delay+1 cycles on.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (snd_seen) begin
      resp_sent = 1'b0;
      tx_cnt = tx_delay;
    end else if (tx_en && !resp_sent) begin
      if (tx_cnt == 0) begin
        resp_sent = 1'b1;
        rise_cyc = cyc;
      end else begin
        tx_cnt--;
      end
    end
    @(negedge clk);
    snd_seen = snd_resp;
  endtask

  function automatic logic [127:0] shadow_flat();
    logic [127:0] f;
    for (int i = 0; i < 8; i++) f[16*i +: 16] = shadow[i];
    return f;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int npulse;
    int gap;
    logic [7:0] got0;
    logic [7:0] got1;
    npulse = 0;
    gap = -1;
    got0 = '0;
    got1 = '0;
    cmd = v.cmd;
    data = v.data;
    cmd_rdy = 1'b1;
    #1;
    chk($sformatf("v%0d clr_c0", idx), 128'(clr_cmd_rdy), 128'(1'b1));
    chk($sformatf("v%0d busy_c0", idx), 128'(busy), 128'(1'b0));
    cycle();
    cmd_rdy = 1'b0;
    chk($sformatf("v%0d wr_strobe_c1", idx), 128'(wr_strobe), 128'(v.wr));
    if (v.wr) begin
      chk($sformatf("v%0d wr_addr_c1", idx), 128'(wr_addr), 128'(v.cmd[2:0]));
      shadow[v.cmd[2:0]] = v.data;
    end
    chk($sformatf("v%0d busy_c1", idx), 128'(busy), 128'(1'b1));
    chk($sformatf("v%0d tx_err_c1", idx), 128'(tx_err), 128'(1'b0));
    chk($sformatf("v%0d clr_c1", idx), 128'(clr_cmd_rdy), 128'(1'b0));
    cycle();
    chk($sformatf("v%0d regs_c2", idx), regs, shadow_flat());
    chk($sformatf("v%0d snd_c2", idx), 128'(snd_resp), 128'(1'b1));
    for (int k = 0; k < 60 && busy; k++) begin
      if (snd_resp) begin
        if (npulse == 0) got0 = resp;
        if (npulse == 1) begin
          got1 = resp;
          gap = cyc - rise_cyc;
        end
        npulse++;
      end
      cycle();
    end
    chk($sformatf("v%0d idle_after", idx), 128'(busy), 128'(1'b0));
    chk($sformatf("v%0d busy_drop", idx), 128'(cyc), 128'(rise_cyc + 1));
    chk($sformatf("v%0d npulse", idx), 128'(npulse), 128'(v.nresp));
    chk($sformatf("v%0d resp0", idx), 128'(got0), 128'(v.r0));
    if (v.nresp == 2) begin
      chk($sformatf("v%0d resp1", idx), 128'(got1), 128'(v.r1));
      chk($sformatf("v%0d gap2", idx), 128'(gap), 128'(1));
    end
    chk($sformatf("v%0d regs_end", idx), regs, shadow_flat());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " clr"}, 128'(clr_cmd_rdy), 128'(1'b0));
    chk({tag, " snd"}, 128'(snd_resp), 128'(1'b0));
    chk({tag, " wr_strobe"}, 128'(wr_strobe), 128'(1'b0));
    chk({tag, " busy"}, 128'(busy), 128'(1'b0));
    chk({tag, " tx_err"}, 128'(tx_err), 128'(1'b0));
    chk({tag, " resp"}, 128'(resp), 128'(8'h00));
    chk({tag, " wr_addr"}, 128'(wr_addr), 128'(3'd0));
    chk({tag, " regs"}, regs, 128'(0));
  endtask

  initial begin
    int c0;
    int npulse;
    int acc_cyc;
    logic [7:0] exp_hi;

    vecs[0]  = '{8'h13, 16'hBEEF, 1, 8'hA5, 8'h00, 1'b1};
    vecs[1]  = '{8'h23, 16'h0000, 2, 8'hBE, 8'hEF, 1'b0};
    vecs[2]  = '{8'h1B, 16'h1234, 1, 8'hEE, 8'h00, 1'b0};
    vecs[3]  = '{8'h70, 16'h0000, 1, 8'hEE, 8'h00, 1'b0};
    vecs[4]  = '{8'h10, 16'h0102, 1, 8'hA5, 8'h00, 1'b1};
    vecs[5]  = '{8'h17, 16'hFFFF, 1, 8'hA5, 8'h00, 1'b1};
    vecs[6]  = '{8'h27, 16'h0000, 2, 8'hFF, 8'hFF, 1'b0};
    vecs[7]  = '{8'h20, 16'h0000, 2, 8'h01, 8'h02, 1'b0};
    vecs[8]  = '{8'h2B, 16'h0000, 1, 8'hEE, 8'h00, 1'b0};
    vecs[9]  = '{8'h00, 16'h5555, 1, 8'hEE, 8'h00, 1'b0};
    vecs[10] = '{8'h25, 16'h0000, 2, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{8'h13, 16'h1234, 1, 8'hA5, 8'h00, 1'b1};
    vecs[12] = '{8'h23, 16'h0000, 2, 8'h12, 8'h34, 1'b0};

    for (int i = 0; i < 8; i++) shadow[i] = '0;
    rst = 1'b1;
    cmd_rdy = 1'b0;
    cmd = '0;
    data = '0;
    resp_sent = 1'b1;

    cycle();
    cycle();
    chk_reset_outputs("reset");
    rst = 1'b0;
    cycle();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Watchdog: READ whose first byte is never confirmed.
    tx_en = 1'b0;
    cmd = 8'h23;
    data = '0;
    cmd_rdy = 1'b1;
    c0 = cyc;
    cycle();
    cmd_rdy = 1'b0;
    npulse = 0;
    while (cyc < c0 + 2 + int'(TO)) begin
      if (snd_resp) npulse++;
      cycle();
    end
    chk("to last_wait busy", 128'(busy), 128'(1'b1));
    chk("to last_wait tx_err", 128'(tx_err), 128'(1'b0));
    cycle();
    chk("to idle busy", 128'(busy), 128'(1'b0));
    chk("to tx_err set", 128'(tx_err), 128'(1'b1));
    for (int k = 0; k < 5; k++) begin
      if (snd_resp) npulse++;
      cycle();
    end
    chk("to npulse", 128'(npulse), 128'(1));
    chk("to tx_err sticky", 128'(tx_err), 128'(1'b1));
    tx_en = 1'b1;
    run_vec('{8'h14, 16'h5A5A, 1, 8'hA5, 8'h00, 1'b1}, 100);

    // Back-to-back: cmd_rdy held high across a READ.
    exp_hi = shadow[3][15:8];
    cmd = 8'h23;
    cmd_rdy = 1'b1;
    #1;
    chk("b2b clr_first", 128'(clr_cmd_rdy), 128'(1'b1));
    acc_cyc = -1;
    npulse = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (snd_resp) begin
        if (npulse == 0) chk("b2b resp0", 128'(resp), 128'(exp_hi));
        npulse++;
      end
      if (clr_cmd_rdy) begin
        acc_cyc = cyc;
        break;
      end
    end
    chk("b2b accept_cycle", 128'(acc_cyc), 128'(rise_cyc + 1));
    chk("b2b npulse", 128'(npulse), 128'(2));
    cycle();
    cmd_rdy = 1'b0;
    chk("b2b second_busy", 128'(busy), 128'(1'b1));
    for (int k = 0; k < 60 && busy; k++) cycle();
    chk("b2b drained", 128'(busy), 128'(1'b0));

    // Reset while waiting in WAIT_LAST of a WRITE.
    tx_en = 1'b0;
    cmd = 8'h11;
    data = 16'hAAAA;
    cmd_rdy = 1'b1;
    cycle();
    cmd_rdy = 1'b0;
    cycle();
    chk("rst regs_written", 128'(regs[31:16]), 128'(16'hAAAA));
    cycle();
    cycle();
    chk("rst pre busy", 128'(busy), 128'(1'b1));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    cycle();
    chk("post_rst snd", 128'(snd_resp), 128'(1'b0));
    chk("post_rst wr_strobe", 128'(wr_strobe), 128'(1'b0));
    chk("post_rst busy", 128'(busy), 128'(1'b0));
    tx_en = 1'b1;
    run_vec('{8'h21, 16'h0000, 2, 8'h00, 8'h00, 1'b0}, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
